dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port word-addressed data memory. It shares the memory between the core load/store path (port 0) and the program/debug loader (port 1). Each port uses a valid/ready request and a one-cycle response pulse. The block registers the winning request, drives the memory control lines for exactly one cycle, and returns registered read data together with an out-of-range error flag.

## Interface
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width
- MEM_WORDS, 256, memory depth in words; legal byte addresses are 0 .. 4*MEM_WORDS-1
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port accept; at most one bit high
- req_we  in  2  per-port write enable (1 = store, 0 = load)
- req_addr0 / req_addr1  in  ADDR_W  byte address; bits [1:0] ignored
- req_wdata0 / req_wdata1  in  DATA_W  store data
- resp_valid  out  2  one-cycle response pulse to the port that was served
- resp_rdata  out  DATA_W  load data; valid while any resp_valid bit is high
- resp_err  out  1  address out of range; valid with resp_valid
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory write_data
- mem_read / mem_write  out  1  to memory strobes
- mem_rdata  in  DATA_W  from memory read_data (combinational read)

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset enters IDLE.
- **IDLE**
  - The picker selects `gnt` from req_valid.
  - req_ready[gnt] = 1 when any valid is high.
  - On valid&&ready, register port, we, addr, wdata, and err = (addr >= 4*MEM_WORDS). Then go to ACCESS.
  - With no valid, stay in IDLE and keep all ready bits 0.
- **ACCESS** (one cycle)
  - Drive mem_addr from the registered addr.
  - mem_write = we && !err; mem_read = !we && !err.
  - At the end of the cycle, capture rdata = (!we && !err) ? mem_rdata : 0.
  - Go to RESP.
- **RESP** (one cycle)
  - resp_valid[port] = 1, with resp_rdata and resp_err driven.
  - Then go to IDLE.
- mem_read and mem_write are 0 in every state except ACCESS. mem_addr and mem_wdata hold their last registered values.
- Requesters hold valid, addr, we and wdata stable until ready. Deassertion before ready is legal; the request is then dropped without side effects.
- Fixed priority (macro absent): port 0 wins whenever both are valid.
- Stores return resp_valid with resp_rdata = 0. An out-of-range store performs no memory write and returns resp_err = 1.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - RR pointer: 0.
- Latency: accept at edge N, memory strobe during cycle N+1, resp_valid during cycle N+2.
- The next accept is possible at edge N+3, giving a throughput of 1 access per 3 cycles.
- req_ready is combinational from state and req_valid. resp_* and mem_* are registered or derived from state only, never from the req_* inputs.
- A rst pulse in any state returns to IDLE on that edge:
  - A response in flight is discarded and no resp_valid is issued.
  - If rst is high during ACCESS, mem_write is forced to 0 in that cycle, so the store is not performed.
- Memory contents are not affected by rst.

## Configuration
- Macro DMEM_ARB_RR_EN.
- When defined:
  - A 1-bit pointer records the last granted port.
  - When both ports are valid in IDLE, the other port wins.
  - The pointer updates only on accept.
- When undefined: fixed priority to port 0, and no pointer flop is present.
- All other behaviour is identical in both builds.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum (IDLE/ACCESS/RESP)
  - the default value for MEM_WORDS
  - the port index constants PORT_CORE = 0 and PORT_LOADER = 1
- Sub-module `dmem_arb_pick` is combinational.
  - Inputs: req_valid[1:0] and, under the macro only, the pointer.
  - Outputs: gnt index and any_valid.
- The top level holds the FSM, request registers, response registers and memory drive.

## Test plan
- **Single load:** memory word 3 = 0xDEADBEEF, port 0 loads addr 0x0C. Required: mem_read high exactly 1 cycle; resp_valid = 2'b01 two cycles after accept; resp_rdata = 0xDEADBEEF; resp_err = 0.
- **Store then load:** port 1 stores 0x12345678 to 0x40, then loads 0x40. Required: resp_rdata = 0x12345678; mem_write high exactly 1 cycle.
- **Simultaneous requests, fixed priority:** both ports valid continuously. Required: macro off, port 0 is granted every time; macro on, grants alternate 0, 1, 0, 1.
- **Out-of-range:** store and load to 0x400 with MEM_WORDS = 256. Required: no mem strobe; resp_err = 1; resp_rdata = 0; memory unchanged.
- **Reset mid-store:** rst high during ACCESS of a store. Required: no mem_write; no resp_valid; all outputs at reset values; the next request is served normally.
- **Withdrawn request:** port 1 raises valid while port 0 is being served and drops it before ready. Required: no access and no response for port 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory arbiter: the sequencer state
// encoding, the default memory depth and the port index constants.
// Optional feature macro used by the importing files: DMEM_ARB_RR_EN.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int MEM_WORDS_DEFAULT = 256;

   localparam logic PORT_CORE   = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
// Combinational grant picker for the two request ports.
// Ports:
//   req_valid [1:0]  per-port request valid
//   last_gnt         last granted port (only when DMEM_ARB_RR_EN is defined)
//   gnt              index of the winning port
//   any_valid        at least one port is requesting
// Macro DMEM_ARB_RR_EN: when defined, a contested grant goes to the port
// that did not win last time; otherwise the core port always wins.
module dmem_arb_pick
   import dmem_pkg::*;
(
   input  logic [1:0] req_valid,
`ifdef DMEM_ARB_RR_EN
   input  logic       last_gnt,
`endif
   output logic       gnt,
   output logic       any_valid
);

   assign any_valid = |req_valid;

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      gnt = PORT_CORE;
      if (req_valid == 2'b11)
         gnt = ~last_gnt;
      else if (!req_valid[PORT_CORE])
         gnt = PORT_LOADER;
   end
`else
   // Core port wins whenever it asks; loader only gets a lone request.
   assign gnt = req_valid[PORT_CORE] ? PORT_CORE : PORT_LOADER;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares a single-port word-addressed data memory between the core
// load/store path (port 0) and the program/debug loader (port 1).
// Each access takes three cycles: accept (IDLE), memory strobe (ACCESS),
// response pulse (RESP).
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/req_ready/req_we      per-port handshake and write enable
//   req_addr0/1, req_wdata0/1       per-port byte address and store data
//   resp_valid, resp_rdata, resp_err  one-cycle response to the served port
//   mem_addr (word address), mem_wdata, mem_read, mem_write, mem_rdata
// Macro DMEM_ARB_RR_EN: enables round-robin arbitration with a 1-bit
// last-grant pointer; default build uses fixed priority to port 0.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_we,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   // One past the last legal byte address; one extra bit so large
   // MEM_WORDS values cannot wrap the compare.
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * MEM_WORDS);

   state_t            state_reg;
   logic              port_reg;
   logic              err_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              mem_read_reg;
   logic              mem_write_reg;
   logic [1:0]        resp_valid_reg;
   logic [DATA_W-1:0] resp_rdata_reg;
   logic              resp_err_reg;

   logic              gnt;
   logic              any_valid;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              sel_err;

`ifdef DMEM_ARB_RR_EN
   logic              ptr_reg;
`endif

   dmem_arb_pick u_pick (
      .req_valid (req_valid),
`ifdef DMEM_ARB_RR_EN
      .last_gnt  (ptr_reg),
`endif
      .gnt       (gnt),
      .any_valid (any_valid)
   );

   assign sel_addr  = (gnt == PORT_LOADER) ? req_addr1  : req_addr0;
   assign sel_wdata = (gnt == PORT_LOADER) ? req_wdata1 : req_wdata0;
   assign sel_we    = req_we[gnt];
   assign sel_err   = ({1'b0, sel_addr} >= ADDR_LIMIT);

   // Ready only in IDLE, so valid&&ready is simply any_valid there.
   always_comb begin
      req_ready = 2'b00;
      if (state_reg == IDLE && any_valid)
         req_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         port_reg       <= PORT_CORE;
         err_reg        <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         resp_valid_reg <= 2'b00;
         resp_rdata_reg <= '0;
         resp_err_reg   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         ptr_reg        <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_valid) begin
                  port_reg      <= gnt;
                  err_reg       <= sel_err;
                  addr_reg      <= sel_addr;
                  wdata_reg     <= sel_wdata;
                  // Strobes are decided at accept so they are pure flops
                  // during ACCESS.
                  mem_read_reg  <= !sel_we && !sel_err;
                  mem_write_reg <= sel_we && !sel_err;
`ifdef DMEM_ARB_RR_EN
                  ptr_reg       <= gnt;
`endif
                  state_reg     <= ACCESS;
               end
            end
            ACCESS: begin
               mem_read_reg   <= 1'b0;
               mem_write_reg  <= 1'b0;
               resp_rdata_reg <= mem_read_reg ? mem_rdata : '0;
               resp_err_reg   <= err_reg;
               resp_valid_reg <= (port_reg == PORT_LOADER) ? 2'b10 : 2'b01;
               state_reg      <= RESP;
            end
            RESP: begin
               resp_valid_reg <= 2'b00;
               resp_rdata_reg <= '0;
               resp_err_reg   <= 1'b0;
               state_reg      <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Memory is word addressed; the byte offset bits are dropped.
   assign mem_addr   = {2'b00, addr_reg[ADDR_W-1:2]};
   assign mem_wdata  = wdata_reg;
   // A reset arriving during ACCESS must cancel the store on that same edge.
   assign mem_read   = mem_read_reg && !rst;
   assign mem_write  = mem_write_reg && !rst;
   assign resp_valid = resp_valid_reg;
   assign resp_rdata = resp_rdata_reg;
   assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter: expected responses are queued at
// accept time from a reference memory and checked when resp_valid pulses.
// Works in both builds (DMEM_ARB_RR_EN defined or not).
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
   logic [1:0]  resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   dmem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory seen by the DUT
   logic [31:0] mem_array [256];
   logic        load_mem;

   function automatic logic [31:0] init_word(input int i);
      return (i == 3) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i));
   endfunction

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem_array[i] <= init_word(i);
      end else if (mem_write && mem_addr < 32'd256) begin
         mem_array[mem_addr[7:0]] <= mem_wdata;
      end
   end
   assign mem_rdata = (mem_addr < 32'd256) ? mem_array[mem_addr[7:0]] : 32'h0;

   // Reference model and scoreboard
   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] ref_mem [256];
   logic        ptr_model;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at the negedge before the accepting edge.
   task automatic push_exp(input logic p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd);
      exp_t e;
      e.port  = p;
      e.err   = (addr >= 32'h400);
      e.rdata = (!we && !e.err) ? ref_mem[addr[9:2]] : 32'h0;
      e.cyc   = cyc + 2;
      if (we && !e.err) ref_mem[addr[9:2]] = wd;
      ptr_model = p;
      exp_q.push_back(e);
      $display("[TB] accept port%0d %s addr=%h wdata=%h", p, we ? "store" : "load", addr, wd);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      if (resp_valid != 2'b00) begin
         resp_cnt++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_resp", {30'd0, resp_valid}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            $display("[TB] resp valid=%b rdata=%h err=%b", resp_valid, resp_rdata, resp_err);
            check_val("resp_port", {30'd0, resp_valid}, e.port ? 32'd2 : 32'd1);
            check_val("resp_rdata", resp_rdata, e.rdata);
            check_val("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            check_val("resp_latency", cyc, e.cyc);
         end
      end
   end

   task automatic drive_port(input int p, input logic v, input logic we,
                             input logic [31:0] addr, input logic [31:0] wd);
      req_valid[p] = v;
      req_we[p]    = we;
      if (p == 0) begin req_addr0 = addr; req_wdata0 = wd; end
      else        begin req_addr1 = addr; req_wdata1 = wd; end
   endtask

   task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
      bit done = 0;
      @(negedge clk);
      drive_port(p, 1'b1, we, addr, wd);
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (req_ready[p]) begin
            push_exp(p[0], we, addr, wd);
            done = 1;
            @(posedge clk);
            #1 req_valid[p] = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         check_val("accept_timeout", 32'd0, 32'd1);
         req_valid[p] = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         check_val("resp_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_resp_valid"}, {30'd0, resp_valid}, 32'd0);
      check_val({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      check_val({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
      check_val({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
      check_val({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
      check_val({tag, "_mem_addr"}, mem_addr, 32'd0);
      check_val({tag, "_mem_wdata"}, mem_wdata, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1);
   end

   initial begin
      int  rd0, wr0, rs0, n;
      logic g, exp_g;

      rst = 1'b1; load_mem = 1'b1; ptr_model = 1'b0;
      req_valid = 2'b00; req_we = 2'b00;
      req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      repeat (2) @(posedge clk);
      load_mem = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      check_val("reset_req_ready", {30'd0, req_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single load
      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(0, 1'b0, 32'h0C, 32'h0);
      drain();
      check_val("load_read_cycles", rd_cnt - rd0, 32'd1);
      check_val("load_write_cycles", wr_cnt - wr0, 32'd0);

      // Store then load from the loader port
      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(1, 1'b1, 32'h40, 32'h12345678);
      do_req(1, 1'b0, 32'h40, 32'h0);
      drain();
      check_val("st_ld_write_cycles", wr_cnt - wr0, 32'd1);
      check_val("st_ld_read_cycles", rd_cnt - rd0, 32'd1);

      // Both ports valid continuously
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 32'h0C, 32'h0);
      drive_port(1, 1'b1, 1'b0, 32'h40, 32'h0);
      n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         #1;
         if (req_ready != 2'b00) begin
            g = req_ready[1];
`ifdef DMEM_ARB_RR_EN
            exp_g = ~ptr_model;
`else
            exp_g = 1'b0;
`endif
            check_val("ready_onehot", $countones(req_ready), 32'd1);
            check_val("grant", {31'd0, g}, {31'd0, exp_g});
            push_exp(g, 1'b0, g ? req_addr1 : req_addr0, 32'h0);
            n++;
            @(posedge clk);
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      check_val("grant_count", n, 32'd4);
      drain();

      // Out-of-range store and load
      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(0, 1'b1, 32'h400, 32'hBAD0BAD0);
      do_req(1, 1'b0, 32'h400, 32'h0);
      drain();
      check_val("oor_read_cycles", rd_cnt - rd0, 32'd0);
      check_val("oor_write_cycles", wr_cnt - wr0, 32'd0);
      check_val("oor_mem0", mem_array[0], ref_mem[0]);
      check_val("oor_mem255", mem_array[255], ref_mem[255]);

      // Reset during ACCESS of a store
      wr0 = wr_cnt; rs0 = resp_cnt;
      @(negedge clk);
      drive_port(0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
      #1 check_val("rst_accept_ready", {30'd0, req_ready}, 32'd1);
      $display("[TB] accept port0 store addr=00000020 (reset follows)");
      @(posedge clk);
      #1 req_valid[0] = 1'b0; rst = 1'b1;
      #1 check_val("rst_mem_write", {31'd0, mem_write}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("post_rst");
      repeat (4) @(negedge clk);
      check_val("rst_no_resp", resp_cnt - rs0, 32'd0);
      check_val("rst_no_write", wr_cnt - wr0, 32'd0);
      check_val("rst_mem_word", mem_array[8], ref_mem[8]);
      rd0 = rd_cnt;
      do_req(0, 1'b0, 32'h20, 32'h0);
      drain();
      check_val("post_rst_read_cycles", rd_cnt - rd0, 32'd1);

      // Loader request withdrawn before it is ever ready
      wr0 = wr_cnt; rs0 = resp_cnt;
      @(negedge clk);
      drive_port(0, 1'b1, 1'b0, 32'h0C, 32'h0);
      #1;
      if (req_ready[0]) push_exp(1'b0, 1'b0, 32'h0C, 32'h0);
      else check_val("wd_accept_ready", {30'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      drive_port(1, 1'b1, 1'b1, 32'h80, 32'h55555555);
      #1 check_val("wd_ready_access", {30'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 check_val("wd_ready_resp", {30'd0, req_ready}, 32'd0);
      req_valid[1] = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check_val("wd_resp_count", resp_cnt - rs0, 32'd1);
      check_val("wd_write_cycles", wr_cnt - wr0, 32'd0);
      check_val("wd_mem_word", mem_array[32], ref_mem[32]);

      check_val("queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
